// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Purpose  : Note-event scheduler. Assigns note-on events to synth voices
//             (free, then released, then steal the oldest gated voice) and
//             routes note-off events to the voice holding the key. Scans one
//             voice per cycle, then issues one registered strobe per event.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
   parameter int VOICES  = 4,
   parameter int V_WIDTH = $clog2(VOICES)
) (
   input  logic               CLOCK_25,
   input  logic               iRST_N,
   input  logic               ev_valid,
   input  logic               ev_on,
   input  logic [6:0]         ev_key,
   input  logic [6:0]         ev_vel,
   output logic               ev_ready,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic               note_on,
   output logic               note_off,
   output logic               steal,
   output logic               off_note_error,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic [V_WIDTH:0]   active_keys
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   localparam logic [V_WIDTH-1:0] c_last_idx = V_WIDTH'(VOICES - 1);
   localparam logic [7:0]         c_age_max  = 8'hFF;

   state_t r_state;
   state_t w_next_state;

   // Per-voice tables
   logic [6:0]         r_key [VOICES];
   logic [7:0]         r_age [VOICES];
   logic [VOICES-1:0]  r_gate;

   // Latched event (r_ev_on already folds velocity-0 note-ons into note-offs)
   logic               r_ev_on;
   logic [6:0]         r_ev_key;
   logic [6:0]         r_ev_vel;

   // Scan position and per-class candidates
   logic [V_WIDTH-1:0] r_index;
   logic               r_has_match, r_has_free, r_has_rel, r_has_old;
   logic [V_WIDTH-1:0] r_match_idx, r_free_idx, r_rel_idx, r_old_idx;
   logic [7:0]         r_rel_age, r_old_age;

   // Stays low through reset so ev_ready rises on the first edge after release
   logic               r_ready_en;

   logic               w_accept;
   logic               w_cur_gate, w_cur_free;
   logic [6:0]         w_cur_key;
   logic [7:0]         w_cur_age;
   logic               w_do_on, w_do_off, w_do_err, w_do_steal;
   logic [V_WIDTH-1:0] w_sel_idx;
   logic [VOICES-1:0]  w_gate_next;

   function automatic logic [V_WIDTH:0] popcount(input logic [VOICES-1:0] bits);
      logic [V_WIDTH:0] sum;
      sum = '0;
      for (int i = 0; i < VOICES; i++) begin
         sum = sum + {{V_WIDTH{1'b0}}, bits[i]};
      end
      return sum;
   endfunction

   assign ev_ready   = (r_state == S_IDLE) && r_ready_en;
   assign w_accept   = ev_valid && ev_ready;
   assign keys_on    = r_gate;

   assign w_cur_gate = r_gate[r_index];
   assign w_cur_free = voice_free[r_index];
   assign w_cur_key  = r_key[r_index];
   assign w_cur_age  = r_age[r_index];

   // State register
   always_ff @(posedge CLOCK_25) begin
      if (!iRST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: accept, walk every voice once, then issue
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_SCAN;
         S_SCAN:  if (r_index == c_last_idx) w_next_state = S_ISSUE;
         S_ISSUE: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Final choice from the scanned candidates, in priority order
   always_comb begin
      w_do_on    = 1'b0;
      w_do_off   = 1'b0;
      w_do_err   = 1'b0;
      w_do_steal = 1'b0;
      w_sel_idx  = '0;
      if (r_ev_on) begin
         if (r_has_match) begin
            w_do_on   = 1'b1;
            w_sel_idx = r_match_idx;
         end else if (r_has_free) begin
            w_do_on   = 1'b1;
            w_sel_idx = r_free_idx;
         end else if (r_has_rel) begin
            w_do_on   = 1'b1;
            w_sel_idx = r_rel_idx;
         end else if (r_has_old) begin
            w_do_on    = 1'b1;
            w_do_steal = 1'b1;
            w_sel_idx  = r_old_idx;
         end
      end else begin
         if (r_has_match) begin
            w_do_off  = 1'b1;
            w_sel_idx = r_match_idx;
         end else begin
            w_do_err  = 1'b1;
         end
      end
   end

   // Gate vector as it will look after this event commits
   always_comb begin
      w_gate_next = r_gate;
      if (w_do_on) begin
         w_gate_next[w_sel_idx] = 1'b1;
      end else if (w_do_off) begin
         w_gate_next[w_sel_idx] = 1'b0;
      end
   end

   // Datapath: event latch, candidate scan, commit and output registers
   always_ff @(posedge CLOCK_25) begin
      if (!iRST_N) begin
         for (int v = 0; v < VOICES; v++) begin
            r_key[v] <= '0;
            r_age[v] <= '0;
         end
         r_gate         <= '0;
         r_ev_on        <= 1'b0;
         r_ev_key       <= '0;
         r_ev_vel       <= '0;
         r_index        <= '0;
         r_has_match    <= 1'b0;
         r_has_free     <= 1'b0;
         r_has_rel      <= 1'b0;
         r_has_old      <= 1'b0;
         r_match_idx    <= '0;
         r_free_idx     <= '0;
         r_rel_idx      <= '0;
         r_old_idx      <= '0;
         r_rel_age      <= '0;
         r_old_age      <= '0;
         r_ready_en     <= 1'b0;
         note_on        <= 1'b0;
         note_off       <= 1'b0;
         steal          <= 1'b0;
         off_note_error <= 1'b0;
         cur_key_adr    <= '0;
         cur_key_val    <= '0;
         cur_vel_on     <= '0;
         cur_vel_off    <= '0;
         active_keys    <= '0;
      end else begin
         r_ready_en     <= 1'b1;
         note_on        <= 1'b0;
         note_off       <= 1'b0;
         steal          <= 1'b0;
         off_note_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ev_on     <= ev_on && (ev_vel != 7'd0);
                  r_ev_key    <= ev_key;
                  r_ev_vel    <= ev_vel;
                  r_index     <= '0;
                  r_has_match <= 1'b0;
                  r_has_free  <= 1'b0;
                  r_has_rel   <= 1'b0;
                  r_has_old   <= 1'b0;
                  r_rel_age   <= '0;
                  r_old_age   <= '0;
               end
            end
            S_SCAN: begin
               // First hit wins for match/free; strict compare keeps the
               // lowest index on equal ages
               if (w_cur_gate && (w_cur_key == r_ev_key) && !r_has_match) begin
                  r_has_match <= 1'b1;
                  r_match_idx <= r_index;
               end
               if (!w_cur_gate && w_cur_free && !r_has_free) begin
                  r_has_free <= 1'b1;
                  r_free_idx <= r_index;
               end
               if (!w_cur_gate && (!r_has_rel || (w_cur_age > r_rel_age))) begin
                  r_has_rel <= 1'b1;
                  r_rel_idx <= r_index;
                  r_rel_age <= w_cur_age;
               end
               if (w_cur_gate && (!r_has_old || (w_cur_age > r_old_age))) begin
                  r_has_old <= 1'b1;
                  r_old_idx <= r_index;
                  r_old_age <= w_cur_age;
               end
               r_index <= r_index + V_WIDTH'(1);
            end
            S_ISSUE: begin
               r_gate      <= w_gate_next;
               active_keys <= popcount(w_gate_next);
               if (w_do_on) begin
                  r_key[w_sel_idx] <= r_ev_key;
                  for (int v = 0; v < VOICES; v++) begin
                     if (w_sel_idx == V_WIDTH'(v)) begin
                        r_age[v] <= '0;
                     end else if (r_age[v] != c_age_max) begin
                        r_age[v] <= r_age[v] + 8'd1;
                     end
                  end
                  note_on     <= 1'b1;
                  steal       <= w_do_steal;
                  cur_key_adr <= w_sel_idx;
                  cur_key_val <= {1'b0, r_ev_key};
                  cur_vel_on  <= {1'b0, r_ev_vel};
               end
               if (w_do_off) begin
                  note_off    <= 1'b1;
                  cur_key_adr <= w_sel_idx;
                  cur_vel_off <= {1'b0, r_ev_vel};
               end
               if (w_do_err) begin
                  off_note_error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
# voice_allocator

Note-event scheduler between the MIDI decoder and the synth engine. It accepts note-on/note-off events and assigns each note-on to one of VOICES voices. Free voices are used first, then released voices, then the oldest gated voice is stolen. Note-offs are routed to the voice holding the key. It drives the engine's per-voice key bus (keys_on, note strobes, key/velocity values) and keeps a registered active-voice count.

## Interface
- VOICES, 4, number of synth voices (power of two, 2..64)
- V_WIDTH, utils::clogb2(VOICES), voice index width
- CLOCK_25  in  1  system clock; all logic on rising edge
- iRST_N  in  1  synchronous, active-low reset
- ev_valid  in  1  note event present; held until accepted
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  7  MIDI key number
- ev_vel  in  7  MIDI velocity
- ev_ready  out  1  event accepted on an edge where ev_valid & ev_ready
- voice_free  in  VOICES  from env gen; 1 = voice envelope finished
- keys_on  out  VOICES  gate per voice
- note_on  out  1  one-cycle strobe: voice cur_key_adr (re)triggered
- note_off  out  1  one-cycle strobe: voice cur_key_adr released
- steal  out  1  one-cycle strobe, coincident with note_on, gated voice stolen
- off_note_error  out  1  one-cycle strobe: note-off matched no gated voice
- cur_key_adr  out  V_WIDTH  voice index of last issued event
- cur_key_val  out  8  {1'b0, key} of last note-on
- cur_vel_on  out  8  {1'b0, vel} of last note-on
- cur_vel_off  out  8  {1'b0, vel} of last note-off
- active_keys  out  V_WIDTH+1  popcount(keys_on)

## Operation
- Per-voice state: key[v] (7b), gate[v] (mirrors keys_on), age[v] (8b, saturating at 255).
- Note-on with ev_vel==0 is treated as a note-off with velocity 0.
- FSM IDLE -> SCAN -> ISSUE -> IDLE.
  - IDLE: ev_ready=1. On accept, latch on/key/vel, clear candidate registers, index=0, go to SCAN.
  - SCAN: examines one voice per cycle (index 0..VOICES-1), sampling voice_free[index] in that cycle. After index VOICES-1, go to ISSUE.
  - ISSUE: one cycle. Commits the selection, registers the outputs, returns to IDLE.
- Note-on selection, highest priority first. Within a class, ties go to the lowest index.
  1. Gated voice with key[v]==key (retrigger; keys_on unchanged).
  2. !gate & voice_free voice.
  3. !gate voice with the largest age (released, still sounding).
  4. Gated voice with the largest age: steal=1.
- Note-on commit: key[v]<=key, gate[v]<=1, age[v]<=0. Every other voice's age increments, saturating. note_on=1, cur_key_adr=v, cur_key_val and cur_vel_on updated.
- Note-off: first (lowest-index) gated voice with a matching key.
  - Match: gate[v]<=0, note_off=1, cur_key_adr=v, cur_vel_off updated.
  - No match: off_note_error=1 and no other state changes; cur_vel_off is not updated.
- Exactly one of note_on, note_off, off_note_error pulses per accepted event.
- cur_* outputs hold their values between events.

## Timing
- Reset (iRST_N low at an edge): state=IDLE, all tables 0, keys_on=0, active_keys=0, all strobes 0, all cur_* 0, ev_ready=0.
- ev_ready goes to 1 on the first edge with iRST_N high.
- Reset during SCAN or ISSUE aborts the event. It is dropped and no strobe is issued.
- Accept edge E0 (ev_ready drops to 0 after it). SCAN covers E1..E_VOICES. Edge E_{VOICES+1} registers the outputs.
- After E_{VOICES+1}: strobe high for exactly one cycle, and keys_on, active_keys, cur_* take their new values. ev_ready=1 in the same cycle.
- Throughput: one event per VOICES+2 cycles (6 cycles at VOICES=4).
- ev_valid is ignored while ev_ready=0. The upstream block holds the event.
- A voice_free change mid-scan affects only voices not yet scanned.

## Test plan
- Reset, voice_free=4'b1111, note-ons 60/62/64/67 vel 100: voices 0,1,2,3 in order. keys_on 0001→0011→0111→1111, active_keys=4, cur_vel_on=100. Each note_on appears 5 edges after accept.
- From that state, note-off key 62 vel 40: note_off, cur_key_adr=1, keys_on=1101, cur_vel_off=40, active_keys=3. Then note-off key 70: off_note_error pulse, keys_on unchanged.
- All 4 gated, ages {3,2,1,0} for voices 0..3, note-on 72: voice 0 stolen, note_on+steal, cur_key_val=72, age[0]=0.
- Voice 2 gated with key 64, note-on 64 vel 50: retrigger voice 2, keys_on unchanged, cur_vel_on=50, no steal. Note-on 60 vel 0: behaves as note-off of 60.
- Voices 1 and 3 released, voice_free=4'b1000: note-on selects voice 3. Same with voice_free=0: selects whichever of voices 1/3 has the larger age.
- Assert iRST_N low on the second SCAN cycle: no strobe, keys_on=0, ev_ready=1 one edge after release.
